// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_unit
// Description : Operand-forwarding producer and D-stage stall generator.
//               Keeps a small scoreboard of the instructions in E, M and W
//               and derives the forward selects for D, E and M plus the
//               D-stage stall. Optional multiply/divide busy tracking is
//               compiled in with `define HAZARD_MDU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_kind,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic       d_md_use,
    input  logic       e_md_start,
    input  logic       e_md_div,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt,
    output logic       md_busy
);

    // Result kinds produced by the decoder
    localparam logic [1:0] c_KIND_NONE = 2'd0;
    localparam logic [1:0] c_KIND_LINK = 2'd1;
    localparam logic [1:0] c_KIND_ALU  = 2'd2;
    localparam logic [1:0] c_KIND_MEM  = 2'd3;

    // Forward select encoding
    localparam logic [1:0] c_SEL_RF     = 2'd0;
    localparam logic [1:0] c_SEL_M_LINK = 2'd1;
    localparam logic [1:0] c_SEL_M_ALU  = 2'd2;
    localparam logic [1:0] c_SEL_W      = 2'd3;

    // Scoreboard. Only the fields some consumer reads are kept per stage:
    // E needs everything, M needs rt (store data) plus dst/kind, W only dst.
    logic [4:0] r_e_rs;
    logic [4:0] r_e_rt;
    logic [4:0] r_e_dst;
    logic [1:0] r_e_kind;
    logic [4:0] r_m_rt;
    logic [4:0] r_m_dst;
    logic [1:0] r_m_kind;
    logic [4:0] r_w_dst;

    logic       w_hz_stall;
    logic       w_md_stall;
    logic       w_md_busy;
    logic       w_stall;
    logic [4:0] w_d_dst;

    // Select for a consumer register: M (youngest) wins over W; E never
    // forwards, and a load in M has no data yet.
    function automatic logic [1:0] f_fwd_sel(
        input logic [4:0] r,
        input logic [4:0] m_dst,
        input logic [1:0] m_kind,
        input logic [4:0] w_dst
    );
        logic [1:0] sel;
        sel = c_SEL_RF;
        if (r != 5'd0) begin
            if (m_dst == r && m_kind == c_KIND_LINK) begin
                sel = c_SEL_M_LINK;
            end else if (m_dst == r && m_kind == c_KIND_ALU) begin
                sel = c_SEL_M_ALU;
            end else if (w_dst == r) begin
                sel = c_SEL_W;
            end
        end
        return sel;
    endfunction

    // A source must wait if its producer cannot be forwarded in time for the
    // stage (tuse) where the consumer actually needs the value.
    function automatic logic f_src_stall(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] e_dst,
        input logic [1:0] e_kind,
        input logic [4:0] m_dst,
        input logic [1:0] m_kind
    );
        logic hit;
        hit = 1'b0;
        if (r != 5'd0) begin
            case (tuse)
                2'd0:    hit = (e_dst == r) || (m_dst == r && m_kind == c_KIND_MEM);
                2'd1:    hit = (e_dst == r) && (e_kind == c_KIND_MEM);
                default: hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

    assign w_hz_stall = d_valid &&
                        (f_src_stall(d_rs, d_tuse_rs, r_e_dst, r_e_kind, r_m_dst, r_m_kind) ||
                         f_src_stall(d_rt, d_tuse_rt, r_e_dst, r_e_kind, r_m_dst, r_m_kind));

    assign w_stall = w_hz_stall || w_md_stall;

    // An instruction that writes nothing must never match a consumer
    assign w_d_dst = (d_kind == c_KIND_NONE) ? 5'd0 : d_dst;

    // Advance the scoreboard; a stalled or invalid D becomes a bubble in E
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e_rs   <= 5'd0;
            r_e_rt   <= 5'd0;
            r_e_dst  <= 5'd0;
            r_e_kind <= c_KIND_NONE;
            r_m_rt   <= 5'd0;
            r_m_dst  <= 5'd0;
            r_m_kind <= c_KIND_NONE;
            r_w_dst  <= 5'd0;
        end else begin
            r_w_dst  <= r_m_dst;
            r_m_rt   <= r_e_rt;
            r_m_dst  <= r_e_dst;
            r_m_kind <= r_e_kind;
            if (d_valid && !w_stall) begin
                r_e_rs   <= d_rs;
                r_e_rt   <= d_rt;
                r_e_dst  <= w_d_dst;
                r_e_kind <= d_kind;
            end else begin
                r_e_rs   <= 5'd0;
                r_e_rt   <= 5'd0;
                r_e_dst  <= 5'd0;
                r_e_kind <= c_KIND_NONE;
            end
        end
    end

`ifdef HAZARD_MDU_EN
    localparam logic [3:0] c_MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] c_DIV_LOAD = 4'(DIV_CYCLES);

    logic [3:0] r_md_cnt;

    // Busy countdown for the iterative multiply/divide unit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= 4'd0;
        end else if (e_md_start) begin
            r_md_cnt <= e_md_div ? c_DIV_LOAD : c_MUL_LOAD;
        end else if (r_md_cnt != 4'd0) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

    assign w_md_busy  = (r_md_cnt != 4'd0);
    // The start cycle itself also blocks, since the counter loads only at the edge
    assign w_md_stall = d_md_use && (w_md_busy || e_md_start);
`else
    logic w_unused_md;
    assign w_unused_md = ^{d_md_use, e_md_start, e_md_div, 4'(MUL_CYCLES), 4'(DIV_CYCLES)};
    assign w_md_busy   = 1'b0;
    assign w_md_stall  = 1'b0;
`endif

    assign stall    = w_stall;
    assign md_busy  = w_md_busy;
    assign fwd_d_rs = f_fwd_sel(d_rs,   r_m_dst, r_m_kind, r_w_dst);
    assign fwd_d_rt = f_fwd_sel(d_rt,   r_m_dst, r_m_kind, r_w_dst);
    assign fwd_e_rs = f_fwd_sel(r_e_rs, r_m_dst, r_m_kind, r_w_dst);
    assign fwd_e_rt = f_fwd_sel(r_e_rt, r_m_dst, r_m_kind, r_w_dst);
    // Store in M takes the value retiring from W when it writes the store's rt
    assign fwd_m_rt = (r_w_dst != 5'd0) && (r_w_dst == r_m_rt);

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_fwd_unit
// Description : Self-checking bench for hazard_fwd_unit: directed pipeline
//               sequences from a vector table, reset / multiply-divide
//               corner cases, and random traffic against a pipeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_unit;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_LINK = 2'd1;
    localparam logic [1:0] K_ALU  = 2'd2;
    localparam logic [1:0] K_MEM  = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_kind, d_tuse_rs, d_tuse_rt;
    logic       d_md_use, e_md_start, e_md_div;
    logic       stall, fwd_m_rt, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    int checks   = 0;
    int failures = 0;

    hazard_fwd_unit dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_dst      (d_dst),
        .d_kind     (d_kind),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_md_use   (d_md_use),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .stall      (stall),
        .fwd_d_rs   (fwd_d_rs),
        .fwd_d_rt   (fwd_d_rt),
        .fwd_e_rs   (fwd_e_rs),
        .fwd_e_rt   (fwd_e_rt),
        .fwd_m_rt   (fwd_m_rt),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- helpers
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic st, input logic [1:0] fdrs,
                           input logic [1:0] fdrt, input logic [1:0] fers,
                           input logic [1:0] fert, input logic fm, input logic busy);
        chk({tag, " stall"},    {3'b0, stall},    {3'b0, st});
        chk({tag, " fwd_d_rs"}, {2'b0, fwd_d_rs}, {2'b0, fdrs});
        chk({tag, " fwd_d_rt"}, {2'b0, fwd_d_rt}, {2'b0, fdrt});
        chk({tag, " fwd_e_rs"}, {2'b0, fwd_e_rs}, {2'b0, fers});
        chk({tag, " fwd_e_rt"}, {2'b0, fwd_e_rt}, {2'b0, fert});
        chk({tag, " fwd_m_rt"}, {3'b0, fwd_m_rt}, {3'b0, fm});
        chk({tag, " md_busy"},  {3'b0, md_busy},  {3'b0, busy});
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst, input logic [1:0] kind,
                         input logic [1:0] trs, input logic [1:0] trt);
        d_valid   = v;
        d_rs      = rs;
        d_rt      = rt;
        d_dst     = dst;
        d_kind    = kind;
        d_tuse_rs = trs;
        d_tuse_rt = trt;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 5'd0, K_NONE, 2'd3, 2'd3);
        d_md_use   = 1'b0;
        e_md_start = 1'b0;
        e_md_div   = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        nop();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        logic       v;
        logic [4:0] rs, rt, dst;
        logic [1:0] kind, trs, trt;
        logic       st;
        logic [1:0] fdrs, fdrt, fers, fert;
        logic       fm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic [1:0] kind,
                       input logic [1:0] trs, input logic [1:0] trt,
                       input logic st, input logic [1:0] fdrs, input logic [1:0] fdrt,
                       input logic [1:0] fers, input logic [1:0] fert, input logic fm);
        vec_t e;
        e.v = v; e.rs = rs; e.rt = rt; e.dst = dst; e.kind = kind;
        e.trs = trs; e.trt = trt; e.st = st; e.fdrs = fdrs; e.fdrt = fdrt;
        e.fers = fers; e.fert = fert; e.fm = fm;
        tbl.push_back(e);
    endtask

    task automatic add_nop(input logic [1:0] fers, input logic [1:0] fert, input logic fm);
        add(1'b0, 5'd0, 5'd0, 5'd0, K_NONE, 2'd3, 2'd3, 1'b0, 2'd0, 2'd0, fers, fert, fm);
    endtask

    // --------------------------------------------------------- random model
    typedef struct {
        logic [4:0] rs, rt, dst;
        logic [1:0] kind;
    } ins_t;

    ins_t pipe[3];   // 0 = E, 1 = M, 2 = W
    int   md_left;

    // Pipeline index at which a result of this kind first becomes forwardable
    function automatic int avail_stage(input logic [1:0] kind);
        return (kind == K_MEM) ? 2 : 1;
    endfunction

    // Stall if any in-flight producer of r will not be forwardable by the
    // time the consumer needs it (t cycles from now)
    function automatic logic model_src_stalls(input logic [4:0] r, input logic [1:0] t);
        logic s;
        s = 1'b0;
        if (r != 5'd0)
            for (int k = 0; k < 3; k++)
                if (pipe[k].dst == r && (avail_stage(pipe[k].kind) - k) > int'(t))
                    s = 1'b1;
        return s;
    endfunction

    // Youngest forwardable producer wins
    function automatic logic [1:0] model_sel(input logic [4:0] r);
        if (r == 5'd0) return 2'd0;
        for (int k = 1; k < 3; k++)
            if (pipe[k].dst == r && avail_stage(pipe[k].kind) <= k)
                return (k == 2) ? 2'd3 : ((pipe[k].kind == K_LINK) ? 2'd1 : 2'd2);
        return 2'd0;
    endfunction

    function automatic logic [3:0] md_len(input logic div);
        return div ? 4'd10 : 4'd5;
    endfunction

    task automatic md_run(input logic div);
        int n;
        logic en;
`ifdef HAZARD_MDU_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        n = int'(md_len(div));
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 5'd10, K_ALU, 2'd3, 2'd3);
        d_md_use   = 1'b1;
        e_md_start = 1'b1;
        e_md_div   = div;
        #1;
        chk_all($sformatf("md%0d start", n), en, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            e_md_start = 1'b0;
            #1;
            chk({$sformatf("md%0d c%0d", n, k), " stall"}, {3'b0, stall}, {3'b0, en && (k <= n)});
            chk({$sformatf("md%0d c%0d", n, k), " md_busy"}, {3'b0, md_busy}, {3'b0, en && (k <= n)});
        end
        nop();
    endtask

    // ------------------------------------------------------------- watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------ main
    initial begin
        reset = 1'b0;
        nop();

        // Directed pipeline sequences; each row is one D-stage cycle
        add(1, 1, 2, 8, K_ALU, 1, 1,   0, 0, 0, 0, 0, 0);   // addu $8
        add(1, 8, 8, 9, K_ALU, 1, 1,   0, 0, 0, 0, 0, 0);   // addu $9,$8,$8
        add(1, 8, 9, 10, K_ALU, 1, 1,  0, 2, 0, 2, 2, 0);   // addu $10,$8,$9
        add_nop(3, 2, 1);
        add_nop(0, 0, 1);
        add_nop(0, 0, 0);
        add(1, 4, 8, 8, K_MEM, 1, 3,   0, 0, 0, 0, 0, 0);   // lw $8
        add(1, 8, 0, 9, K_ALU, 1, 1,   1, 0, 0, 0, 0, 0);   // addu $9,$8,$0 stalls
        add(1, 8, 0, 9, K_ALU, 1, 1,   0, 0, 0, 0, 0, 0);   // released
        add_nop(3, 0, 0);
        add_nop(0, 0, 0);
        add_nop(0, 0, 0);
        add(1, 4, 8, 8, K_MEM, 1, 3,   0, 0, 0, 0, 0, 0);   // lw $8
        add(1, 8, 0, 0, K_NONE, 0, 0,  1, 0, 0, 0, 0, 0);   // beq $8,$0 stall 1
        add(1, 8, 0, 0, K_NONE, 0, 0,  1, 0, 0, 0, 0, 0);   // stall 2
        add(1, 8, 0, 0, K_NONE, 0, 0,  0, 3, 0, 0, 0, 0);   // from W
        add_nop(0, 0, 0);
        add_nop(0, 0, 0);
        add(1, 0, 0, 31, K_LINK, 3, 3, 0, 0, 0, 0, 0, 0);   // jal
        add_nop(0, 0, 0);
        add(1, 31, 0, 0, K_NONE, 0, 3, 0, 1, 0, 0, 0, 0);   // jr $31
        add_nop(3, 0, 0);
        add_nop(0, 0, 0);
        add(1, 4, 8, 8, K_MEM, 1, 3,   0, 0, 0, 0, 0, 0);   // lw $8
        add(1, 9, 8, 0, K_NONE, 1, 2,  0, 0, 0, 0, 0, 0);   // sw $8,0($9)
        add_nop(0, 0, 0);
        add_nop(0, 0, 1);
        add_nop(0, 0, 0);
        add(1, 1, 2, 0, K_ALU, 1, 1,   0, 0, 0, 0, 0, 0);   // addu $0
        add(1, 0, 0, 3, K_ALU, 1, 1,   0, 0, 0, 0, 0, 0);   // addu $3,$0,$0
        add_nop(0, 0, 0);
        add_nop(0, 0, 0);
        add(1, 1, 2, 8, K_ALU, 1, 1,   0, 0, 0, 0, 0, 0);   // addu $8
        add(1, 3, 4, 8, K_ALU, 1, 1,   0, 0, 0, 0, 0, 0);   // addu $8 again
        add(1, 8, 8, 9, K_ALU, 1, 1,   0, 2, 2, 0, 0, 0);
        add(1, 8, 0, 10, K_ALU, 1, 1,  0, 2, 0, 2, 2, 0);   // M beats W
        add_nop(3, 0, 1);
        add_nop(0, 0, 0);
        add_nop(0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_all("reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].dst, tbl[i].kind, tbl[i].trs, tbl[i].trt);
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].fdrs, tbl[i].fdrt,
                    tbl[i].fers, tbl[i].fert, tbl[i].fm, 1'b0);
        end

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        drive(1, 1, 2, 8, K_ALU, 1, 1);
        @(negedge clk);
        drive(1, 8, 8, 9, K_ALU, 1, 1);
        @(negedge clk);
        drive(1, 9, 0, 0, K_NONE, 0, 0);            // beq $9 waits on E
        #1;
        chk("pre-reset fwd_e_rs", {2'b0, fwd_e_rs}, 4'd2);
        chk("pre-reset stall", {3'b0, stall}, 4'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        nop();
        reset = 1'b1;
        @(negedge clk);
        drive(1, 8, 8, 11, K_ALU, 0, 0);
        #1;
        chk_all("post-reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);

        // Multiply/divide occupancy
        reset_pulse();
        md_run(1'b1);
        md_run(1'b0);

        // Random traffic against the pipeline model
        reset_pulse();
        for (int k = 0; k < 3; k++) pipe[k] = '{5'd0, 5'd0, 5'd0, K_NONE};
        md_left = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            logic       exp_stall, md_st, exp_busy;
            ins_t       nxt;
            @(negedge clk);
            drive(logic'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            d_md_use   = ($urandom_range(0, 4) == 0);
            e_md_start = ($urandom_range(0, 9) == 0);
            e_md_div   = 1'($urandom_range(0, 1));
            #1;
`ifdef HAZARD_MDU_EN
            exp_busy = (md_left > 0);
            md_st    = d_md_use && (md_left > 0 || e_md_start);
`else
            exp_busy = 1'b0;
            md_st    = 1'b0;
`endif
            exp_stall = md_st || (d_valid && (model_src_stalls(d_rs, d_tuse_rs) ||
                                              model_src_stalls(d_rt, d_tuse_rt)));
            chk_all($sformatf("rand%0d", cyc), exp_stall, model_sel(d_rs), model_sel(d_rt),
                    model_sel(pipe[0].rs), model_sel(pipe[0].rt),
                    (pipe[2].dst != 5'd0) && (pipe[2].dst == pipe[1].rt), exp_busy);
            // Advance the model to match the coming clock edge
            if (d_valid && !exp_stall)
                nxt = '{d_rs, d_rt, (d_kind == K_NONE) ? 5'd0 : d_dst, d_kind};
            else
                nxt = '{5'd0, 5'd0, 5'd0, K_NONE};
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
            if (e_md_start)       md_left = int'(md_len(e_md_div));
            else if (md_left > 0) md_left = md_left - 1;
        end

        @(negedge clk);
        nop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Producer side of the operand-forwarding interface consumed by the execute stage.
- Tracks the destination register and result kind of every in-flight instruction in E, M and W.
- Generates the 2-bit forward selects for D and E, the 1-bit W->M store-data select, and the D-stage stall.
- Sits beside the pipeline registers and is fed by the D-stage decoder.

Parameters:
- MUL_CYCLES, 5, busy cycles for a multiply (optional feature only)
- DIV_CYCLES, 10, busy cycles for a divide (optional feature only)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- d_valid  in  1  D holds a real instruction
- d_rs  in  5  D source rs
- d_rt  in  5  D source rt
- d_dst  in  5  D destination register; 0 = no write
- d_kind  in  2  result kind: 0 NONE, 1 LINK, 2 ALU, 3 MEM
- d_tuse_rs  in  2  stage needing rs: 0 D, 1 E, 2 M, 3 unused
- d_tuse_rt  in  2  same for rt
- d_md_use  in  1  D is mult/div/mfhi/mflo/mthi/mtlo
- e_md_start  in  1  E is starting a mult/div
- e_md_div  in  1  with e_md_start: 1 = divide
- stall  out  1  hold PC and D; inject bubble into E
- fwd_d_rs  out  2  D select: 0 regfile, 1 M link (pc4_M+4), 2 M ALUout, 3 W write data
- fwd_d_rt  out  2  same
- fwd_e_rs  out  2  E ALU operand-1 select, same encoding
- fwd_e_rt  out  2  E ALU operand-2 / store-data select, same encoding
- fwd_m_rt  out  1  M store data: 1 = W write data
- md_busy  out  1  multiply/divide unit busy

Behaviour:
- Scoreboard: three registered entries E, M, W, each {rs, rt, dst, kind}.
- Bubble = all fields zero.
- Reset (reset low, asynchronous): all entries bubble, md counter 0.
  - Outputs then: stall=0, all selects 0, md_busy=0.
- Each rising clk:
  - W <= M, M <= E.
  - E <= D fields if d_valid && !stall, else bubble.
  - dst forced 0 when kind==NONE.
- Availability:
  - Nothing is forwardable from E.
  - M forwards LINK (sel 1) and ALU (sel 2); M MEM is not forwardable.
  - W forwards any kind (sel 3).
- Select for a consumer register r at D or E:
  - r==0 -> 0.
  - Else M.dst==r and kind LINK/ALU -> 1/2.
  - Else W.dst==r -> 3.
  - Else 0.
  - M has priority over W.
- fwd_e_* use the E entry's own rs/rt. fwd_m_rt = (W.dst!=0 && W.dst==M.rt).
- Selects and stall are combinational from registered state plus D inputs; zero-cycle path.
- Stall, per source register r with tuse t, only when r!=0 and d_valid:
  - t==0: stall if E.dst==r, or if M.dst==r with kind MEM.
  - t==1: stall if E.dst==r with kind MEM.
  - t>=2: never stall.
- Simultaneous hits in M and W on the same register: M wins (youngest value).
- During a stall, the W entry still retires, so a MEM producer moves M->W and the stall clears next cycle.

Optional Feature:
- Macro HAZARD_MDU_EN.
- Defined:
  - A 4-bit down-counter loads MUL_CYCLES or DIV_CYCLES on e_md_start, and decrements to 0 otherwise.
  - md_busy = (counter!=0).
  - Additional stall when d_md_use && (md_busy || e_md_start).
  - Reset clears the counter.
- Undefined:
  - d_md_use, e_md_start and e_md_div are ignored.
  - md_busy tied 0.
  - No extra stall.

Test Plan:
- Reset low mid-stream with E=ALU dst 8 -> all selects 0, stall 0, immediately (async); after release, no forward to $8.
- addu $8 then addu $9,$8,$8 -> next cycle fwd_e_rs=fwd_e_rt=2; one cycle later a consumer of $8 in E gets 3.
- lw $8 then addu $9,$8,$0 -> stall=1 exactly one cycle, E bubble, then fwd_e_rs=3.
- lw $8 then beq $8,$0 (tuse 0) -> stall two cycles, then fwd_d_rs=3; jal ($31, LINK) then jr $31 two later -> fwd_d_rs=1, no stall.
- lw $8 then sw $8,0($9) (rt tuse 2) -> no stall; one cycle after the sw enters E, fwd_m_rt=1. A reg-0 producer/consumer pair -> all selects 0.
- HAZARD_MDU_EN: div starts in E, mflo in D -> stall 11 cycles (start + 10 busy), md_busy high 10 cycles; without macro -> no stall.
